otter_trap_ctrl: RTL
====================

# otter_trap_ctrl

Machine-mode trap sequencer and CSR register file for the pipelined Otter. It sits beside the writeback stage. It commits CSR writes, and takes the external interrupt on a retiring instruction or executes a retiring `mret`. In response it drives the `flush` and `mret` controls consumed by the hazard handler, along with a PC redirect to the fetch stage. It also returns the old CSR value as `csr_out` for writeback and forwarding.

## Interface
- `TRAP_HOLD`, default 2: cooldown cycles after any redirect during which no new trap or `mret` is accepted.
- `CLK` in 1: the single clock.
- `RST` in 1: synchronous, active-high reset.
- `intr` in 1: external interrupt request, level, synchronous to `CLK`.
- `retire` in 1: a valid, non-squashed instruction is in WB this cycle.
- `wb_pc` in 32: PC of the retiring instruction.
- `wb_next_pc` in 32: architectural next PC of the retiring instruction.
- `csr_en` in 1: the retiring instruction is a CSR op.
- `csr_funct3` in 3: 01 = RW, 10 = RS, 11 = RC. Bit 2 is ignored; the immediate is already zero-extended into `csr_wd`.
- `csr_addr` in 12: CSR address.
- `csr_wd` in 32: rs1 value or zimm.
- `mret_in` in 1: the retiring instruction is `mret`.
- `stall` in 1: active-low stall from the hazard handler.
- `csr_out` out 32: combinational old value of `csr_addr`.
- `flush` out 1: registered one-cycle pulse on trap entry.
- `mret` out 1: registered one-cycle pulse on `mret` execution.
- `pc_redirect` out 1: registered one-cycle pulse, equal to `flush | mret`.
- `trap_pc` out 32: redirect target, valid while `pc_redirect` is high.
- `mie_out` out 1: current `mstatus.MIE`.

## Operation
Implemented CSRs:
- `mstatus` 0x300: only bit 3 (MIE) and bit 7 (MPIE) are implemented; all other bits read 0.
- `mie` 0x304: only bit 11 (MEIE).
- `mtvec` 0x305: bits 1:0 are forced to 0.
- `mepc` 0x341: bits 1:0 are forced to 0.
- `mcause` 0x342: full 32 bits.
- `mip` 0x344: read-only; bit 11 reads as `intr`.
- Unimplemented addresses read 0 and ignore writes. Writes to `mip` are ignored.

CSR write rules:
- A write happens when `retire & csr_en & stall`.
- RW: new = `wd`. RS: new = old | `wd`. RC: new = old & ~`wd`.
- RS and RC with `wd` = 0 still count as writes, but have no effect.

Interrupt pending condition: `irq_ok = intr & MIE & MEIE`.

FSM states are IDLE, REDIR and HOLD.
- **IDLE, `mret` path.** On `retire & stall & mret_in`:
  - MIE <= MPIE; MPIE <= 1.
  - Register `mret` = 1 and `trap_pc` = `mepc`.
  - Go to REDIR.
- **IDLE, trap path.** Otherwise, on `retire & stall & irq_ok`:
  - `mepc` <= `wb_next_pc`; `mcause` <= 0x8000000B.
  - MPIE <= MIE; MIE <= 0.
  - Register `flush` = 1 and `trap_pc` = `mtvec`.
  - Go to REDIR.
- **REDIR.** Lasts exactly one cycle, during which the pulses are visible. Load the counter with `TRAP_HOLD` and go to HOLD.
- **HOLD.** Decrement the counter each cycle. At 0, go to IDLE. CSR writes are still committed while in HOLD.

Priority and simultaneous events:
- `mret_in` beats `irq_ok` in the same cycle. The interrupt is re-evaluated on the first retire in IDLE, with the MIE value restored by `mret`.
- A CSR write and a trap in the same cycle: the instruction's write commits first, then the trap field updates override the same bits. Example: writing MIE=1 while a trap is taken leaves MIE=0 and MPIE=1.
- A trap is not taken while `stall` = 0. The retiring instruction is re-presented next cycle.
- `retire` = 0 blocks both the trap and `mret`.
- A `mret_in` or `irq_ok` arriving in REDIR or HOLD is ignored; the instruction is assumed squashed by the hazard handler.
- Reset mid-REDIR or mid-HOLD returns to IDLE with all pulses low.

## Timing
- Reset values:
  - All CSRs are 0; `mtvec` = 0.
  - FSM = IDLE, counter = 0.
  - `flush`, `mret`, `pc_redirect`, `mie_out` = 0; `trap_pc` = 0.
- `csr_out` has zero latency and returns the old value, before any same-cycle write.
- Latency from the qualifying edge to the pulse is 1 cycle. The pulse width is exactly 1 cycle.
- `trap_pc` holds its value until the next redirect.
- CSR updates are visible on `csr_out` the cycle after the write.
- The minimum spacing between redirects is `TRAP_HOLD` + 2 cycles.

## Structure
- Shared package `otter_csr_pkg` holds:
  - CSR address constants (`CSR_MSTATUS`, etc.).
  - Field bit positions (`MSTATUS_MIE` = 3, `MSTATUS_MPIE` = 7, `MIE_MEIE` = 11).
  - `MCAUSE_MEI` = 0x8000000B.
  - The `trap_state_t` enum (IDLE, REDIR, HOLD).
  - The `csr_op_t` enum for funct3.
- One sub-module, `otter_csr_regs`, contains the CSR storage, read mux and RW/RS/RC logic. It has a trap-override port that takes the new mepc, mcause and mstatus values.
- The FSM, counter and output registers are in the top level.

## Test plan
- **Reset and readback.** Assert `RST` for 2 cycles. Then write RW 0x305 with 0x00000103 and read 0x305 → 0x00000100. Read 0x344 while `intr` = 1 → 0x00000800.
- **Interrupt entry.** Set MIE=1, MEIE=1, `mtvec` = 0x200, then raise `intr` while a retire has `wb_next_pc` = 0x44. Next cycle: `flush` = 1, `pc_redirect` = 1, `trap_pc` = 0x200. Afterwards `mepc` = 0x44, `mcause` = 0x8000000B, `mstatus` = 0x80.
- **Return.** Retire `mret` with `mepc` = 0x44 → next cycle `mret` = 1, `trap_pc` = 0x44, and `mstatus` becomes 0x88.
- **Simultaneous `mret` and interrupt.** Retire `mret` with `intr` = 1 in the same cycle → only `mret` pulses. The interrupt then fires on the first retire after `TRAP_HOLD` + 2 cycles.
- **Stall and masking.** With `stall` = 0 during a pending `irq_ok`, there is no pulse; releasing the stall gives a pulse 1 cycle later. With MIE=0 and `intr` = 1, nothing is taken. An RC of 0x300 with 0x8 clears MIE.
- **Reset during HOLD.** Assert `RST` during HOLD → IDLE; a fresh interrupt after reset is blocked because MIE = 0 after reset.

Source files
------------

// File: rtl/otter_csr_pkg.sv
// otter_csr_pkg
// Shared definitions for the Otter machine-mode trap controller:
//   - CSR addresses of the implemented machine CSRs
//   - bit positions of the implemented status/enable fields
//   - the interrupt cause code written on external-interrupt entry
//   - trap sequencer state and CSR operation enums
//   - helpers to decode funct3 and to compute an RW/RS/RC result
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

  // mtvec and mepc hold word-aligned addresses only
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REDIR = 2'b01,
    HOLD  = 2'b10
  } trap_state_t;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  // Bit 2 only distinguishes the immediate forms; the immediate already
  // arrives zero-extended in the write data, so both halves decode alike.
  function automatic csr_op_t csr_decode(input logic [2:0] funct3);
    csr_op_t op;
    case (funct3)
      3'b001, 3'b101: op = CSR_OP_RW;
      3'b010, 3'b110: op = CSR_OP_RS;
      3'b011, 3'b111: op = CSR_OP_RC;
      default:        op = CSR_OP_NONE;
    endcase
    return op;
  endfunction

  // New CSR value for an RW/RS/RC op given the current value
  function automatic logic [31:0] csr_apply(input csr_op_t op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wd);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wd;
      CSR_OP_RS: res = old_val | wd;
      CSR_OP_RC: res = old_val & ~wd;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/otter_csr_regs.sv
// otter_csr_regs
// Machine CSR storage with a combinational old-value read port and the
// RW/RS/RC write path. Trap entry and mret override the fields they own
// after the instruction's own write, so they win on overlapping bits.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   intr              external interrupt level (reflected in mip.MEIP)
//   wr_en, op         commit a CSR write of kind op this cycle
//   addr, wd          CSR address and write operand
//   trap_en           load trap_mepc / trap_mcause (interrupt entry)
//   mst_en            load mst_mie / mst_mpie into mstatus (entry or mret)
//   rdata             old value of addr, zero latency
//   status_mie/mpie   mstatus.MIE / mstatus.MPIE
//   meie              mie.MEIE
//   mtvec, mepc       trap vector and exception PC
module otter_csr_regs
  import otter_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        intr,
  input  logic        wr_en,
  input  csr_op_t     op,
  input  logic [11:0] addr,
  input  logic [31:0] wd,
  input  logic        trap_en,
  input  logic [31:0] trap_mepc,
  input  logic [31:0] trap_mcause,
  input  logic        mst_en,
  input  logic        mst_mie,
  input  logic        mst_mpie,
  output logic [31:0] rdata,
  output logic        status_mie,
  output logic        status_mpie,
  output logic        meie,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  logic [31:0] mcause;
  logic [31:0] wnew;

  // Read mux: old value of the addressed CSR, unimplemented bits read 0
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE]  = status_mie;
        rdata[MSTATUS_MPIE] = status_mpie;
      end
      CSR_MIE:     rdata[MIE_MEIE] = meie;
      CSR_MTVEC:   rdata = mtvec;
      CSR_MEPC:    rdata = mepc;
      CSR_MCAUSE:  rdata = mcause;
      CSR_MIP:     rdata[MIE_MEIE] = intr;
      default:     rdata = 32'h0000_0000;
    endcase
  end

  assign wnew = csr_apply(op, rdata, wd);

  // CSR storage: instruction write first, then trap/mret field overrides
  always_ff @(posedge clk) begin
    if (rst) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      meie        <= 1'b0;
      mtvec       <= 32'h0000_0000;
      mepc        <= 32'h0000_0000;
      mcause      <= 32'h0000_0000;
    end else begin
      if (wr_en) begin
        case (addr)
          CSR_MSTATUS: begin
            status_mie  <= wnew[MSTATUS_MIE];
            status_mpie <= wnew[MSTATUS_MPIE];
          end
          CSR_MIE:    meie   <= wnew[MIE_MEIE];
          CSR_MTVEC:  mtvec  <= wnew & ALIGN_MASK;
          CSR_MEPC:   mepc   <= wnew & ALIGN_MASK;
          CSR_MCAUSE: mcause <= wnew;
          // mip and unimplemented addresses drop the write
          default:    mcause <= mcause;
        endcase
      end
      if (trap_en) begin
        mepc   <= trap_mepc & ALIGN_MASK;
        mcause <= trap_mcause;
      end
      if (mst_en) begin
        status_mie  <= mst_mie;
        status_mpie <= mst_mpie;
      end
    end
  end

endmodule

// File: rtl/otter_trap_ctrl.sv
// otter_trap_ctrl
// Machine-mode trap sequencer beside the WB stage of the pipelined Otter.
// Commits CSR writes, takes the external interrupt or executes mret on a
// retiring instruction, and emits one-cycle flush/mret/redirect pulses with
// the redirect target. After each redirect a cooldown of TRAP_HOLD cycles
// blocks further traps and mrets (redirect spacing >= TRAP_HOLD + 2).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   intr                external interrupt level
//   retire              valid non-squashed instruction in WB
//   wb_pc, wb_next_pc   PC / architectural next PC of that instruction
//   csr_en, csr_funct3  CSR op present and its kind (RW/RS/RC)
//   csr_addr, csr_wd    CSR address and operand
//   mret_in             retiring instruction is mret
//   stall               active-low stall (1 = WB may commit)
//   csr_out             combinational old value of csr_addr
//   flush, mret         registered pulses for trap entry / mret
//   pc_redirect         registered pulse, flush | mret
//   trap_pc             redirect target, held until the next redirect
//   mie_out             current mstatus.MIE
module otter_trap_ctrl
  import otter_csr_pkg::*;
#(
  parameter int TRAP_HOLD = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        intr,
  input  logic        retire,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_next_pc,
  input  logic        csr_en,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  input  logic        mret_in,
  input  logic        stall,
  output logic [31:0] csr_out,
  output logic        flush,
  output logic        mret,
  output logic        pc_redirect,
  output logic [31:0] trap_pc,
  output logic        mie_out
);

  localparam int CNT_W = (TRAP_HOLD > 1) ? $clog2(TRAP_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  trap_state_t      state;
  logic [CNT_W-1:0] hold_cnt;

  csr_op_t     op;
  logic        wr_en;
  logic        commit;
  logic        take_mret;
  logic        take_trap;
  logic        irq_ok;
  logic        status_mie;
  logic        status_mpie;
  logic        meie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mst_en;
  logic        mst_mie;
  logic        mst_mpie;

  // The retiring PC itself is not architecturally needed here
  logic unused_wb_pc;
  assign unused_wb_pc = ^wb_pc;

  assign op        = csr_decode(csr_funct3);
  assign commit    = retire & stall;
  assign wr_en     = commit & csr_en & (op != CSR_OP_NONE);
  assign irq_ok    = intr & status_mie & meie;
  assign take_mret = (state == IDLE) & commit & mret_in;
  assign take_trap = (state == IDLE) & commit & irq_ok & ~mret_in;

  // mstatus override: entry stacks MIE into MPIE, mret restores it
  always_comb begin
    mst_en   = take_mret | take_trap;
    mst_mie  = 1'b0;
    mst_mpie = 1'b0;
    if (take_mret) begin
      mst_mie  = status_mpie;
      mst_mpie = 1'b1;
    end else begin
      mst_mie  = 1'b0;
      mst_mpie = status_mie;
    end
  end

  otter_csr_regs u_regs (
    .clk         (CLK),
    .rst         (RST),
    .intr        (intr),
    .wr_en       (wr_en),
    .op          (op),
    .addr        (csr_addr),
    .wd          (csr_wd),
    .trap_en     (take_trap),
    .trap_mepc   (wb_next_pc),
    .trap_mcause (MCAUSE_MEI),
    .mst_en      (mst_en),
    .mst_mie     (mst_mie),
    .mst_mpie    (mst_mpie),
    .rdata       (csr_out),
    .status_mie  (status_mie),
    .status_mpie (status_mpie),
    .meie        (meie),
    .mtvec       (mtvec),
    .mepc        (mepc)
  );

  assign mie_out = status_mie;

  // Trap sequencer: redirect pulses, target register and cooldown counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      hold_cnt    <= {CNT_W{1'b0}};
      flush       <= 1'b0;
      mret        <= 1'b0;
      pc_redirect <= 1'b0;
      trap_pc     <= 32'h0000_0000;
    end else begin
      flush       <= 1'b0;
      mret        <= 1'b0;
      pc_redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (take_mret) begin
            mret        <= 1'b1;
            pc_redirect <= 1'b1;
            trap_pc     <= mepc;
            state       <= REDIR;
          end else if (take_trap) begin
            flush       <= 1'b1;
            pc_redirect <= 1'b1;
            trap_pc     <= mtvec;
            state       <= REDIR;
          end else begin
            state <= IDLE;
          end
        end
        REDIR: begin
          hold_cnt <= CNT_W'(TRAP_HOLD);
          // With no cooldown configured HOLD is skipped entirely
          if (TRAP_HOLD < 1) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // Leaving on the last count keeps HOLD exactly TRAP_HOLD cycles
          if (hold_cnt <= CNT_ONE) begin
            hold_cnt <= {CNT_W{1'b0}};
            state    <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_ONE;
          end
        end
        default: begin
          hold_cnt <= {CNT_W{1'b0}};
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
